memory_stage: RTL and testbench
===============================

Name: memory_stage

Overview:
- Memory stage of the 16-bit pipelined RISC core, directly upstream of the write-back stage.
- Performs data-memory load/store, stack push/pop, and 32-bit PC push/pop for call/return/interrupt.
- Ends in the MEM/WB pipeline register, which feeds write-back the load data, ALU result, write-back select and port-write flag.
- A two-state FSM handles 32-bit stack transfers over two cycles and stalls upstream meanwhile.

Parameters:
- ADDR_W, 11, data-memory address width; depth is 2**ADDR_W 16-bit words.
- SP_RESET, 2**ADDR_W-1, stack-pointer value after reset.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset (sampled on clk rising edge; 0 = reset).
- mem_read  input  1  load: read mem[alu_result[ADDR_W-1:0]].
- mem_write  input  1  store: write rd_data to mem[alu_result[ADDR_W-1:0]].
- push  input  1  push rd_data (16-bit).
- pop  input  1  pop 16-bit word into load path.
- push_pc  input  1  push pc_in (32-bit, two cycles).
- pop_pc  input  1  pop 32-bit PC (two cycles).
- alu_result  input  16  address for load/store; passed through as Rd value.
- rd_data  input  16  store/push data.
- pc_in  input  32  PC to push.
- wb_in  input  1  write-back select (1 = load data, 0 = ALU result).
- port_write_in  input  1  instruction writes output port.
- rd_addr_in  input  3  destination register index.
- reg_write_in  input  1  instruction writes register file.
- load_out  output  16  registered memory data to write-back.
- rd_out  output  16  registered alu_result.
- wb_out  output  1  registered wb_in.
- port_write_out  output  1  registered port_write_in.
- rd_addr_out  output  3  registered rd_addr_in.
- reg_write_out  output  1  registered reg_write_in.
- pc_out  output  32  popped PC.
- pc_valid  output  1  one-cycle pulse, pc_out valid.
- stall  output  1  combinational; upstream must hold all inputs while 1.
- sp_out  output  ADDR_W  current stack pointer.

Behaviour:
- Memory: internal array; asynchronous read, synchronous write; not cleared by reset.
- Reset (rst=0 at edge): SP=SP_RESET, state=IDLE. load_out, rd_out, pc_out = 0. wb_out, port_write_out, reg_write_out, pc_valid = 0. rd_addr_out = 0.
- Command priority in IDLE (one acted on): pop_pc > push_pc > pop > push > mem_write > mem_read. Lower-priority commands asserted together are ignored.
- Latency: one cycle from inputs to the MEM/WB register outputs.
- Load: load_out <= mem[addr].
- Store: mem[addr] <= rd_data; load_out <= 0.
- push: mem[SP] <= rd_data; SP <= SP-1.
- pop: load_out <= mem[SP+1]; SP <= SP+1.
- SP arithmetic is modulo 2**ADDR_W; wrap is silent, with no flag.
- FSM states: IDLE, SECOND.
  - IDLE + push_pc: mem[SP] <= pc_in[31:16]; go SECOND.
  - IDLE + pop_pc: capture mem[SP+1] as low half; go SECOND.
  - stall=1 during this first cycle; MEM/WB registers load a bubble (reg_write_out=0, port_write_out=0, wb_out=0).
  - SECOND for push_pc: mem[SP-1] <= pc_in[15:0]; SP <= SP-2; go IDLE.
  - SECOND for pop_pc: pc_out <= {mem[SP+2], low}; SP <= SP+2; pc_valid=1 next cycle; go IDLE.
  - stall=0 in SECOND; the held instruction's fields are registered normally this cycle.
- pc_valid is high for exactly one cycle per pop_pc.
- Inputs that change while stall=1 violate the protocol; behaviour is undefined.
- Reset during SECOND: the second half is aborted. A half-written PC stays in memory, SP returns to SP_RESET, and no pc_valid is issued.

Test Plan:
- Reset, then store 0xBEEF at addr 0x0010, then load 0x0010 with wb_in=1 -> load_out=0xBEEF one cycle after load; wb_out=1.
- From reset SP=0x7FF: push 0x1234, push 0x5678, pop, pop -> load_out 0x5678 then 0x1234; sp_out 0x7FE, 0x7FD, 0x7FE, 0x7FF.
- push_pc pc_in=0xAABBCCDD -> stall high one cycle; mem[0x7FF]=0xAABB, mem[0x7FE]=0xCCDD; SP=0x7FD. Then pop_pc -> pc_out=0xAABBCCDD, pc_valid pulses once, SP=0x7FF.
- SP=0x7FF, pop -> SP wraps to 0x000 and reads mem[0x000]. Then push at SP=0x000 -> SP=0x7FF.
- pop_pc and mem_write asserted together -> only pop_pc executes and memory is unchanged. During the stall cycle: reg_write_out=0, port_write_out=0.
- rst=0 during SECOND of push_pc -> next cycle SP=0x7FF, stall=0, pc_valid=0, all registered outputs 0.

Source files
------------

// File: rtl/memory_stage.sv
// Memory stage of the 16-bit RISC core: data-memory load/store, 16-bit stack
// push/pop and two-cycle 32-bit PC push/pop, ending in the MEM/WB register.
module memory_stage #(
    parameter int                ADDR_W   = 11,
    parameter logic [ADDR_W-1:0] SP_RESET = '1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              push,
    input  logic              pop,
    input  logic              push_pc,
    input  logic              pop_pc,
    input  logic [15:0]       alu_result,
    input  logic [15:0]       rd_data,
    input  logic [31:0]       pc_in,
    input  logic              wb_in,
    input  logic              port_write_in,
    input  logic [2:0]        rd_addr_in,
    input  logic              reg_write_in,
    output logic [15:0]       load_out,
    output logic [15:0]       rd_out,
    output logic              wb_out,
    output logic              port_write_out,
    output logic [2:0]        rd_addr_out,
    output logic              reg_write_out,
    output logic [31:0]       pc_out,
    output logic              pc_valid,
    output logic              stall,
    output logic [ADDR_W-1:0] sp_out
);

    // state  | meaning
    // IDLE   | single-cycle commands; first half of a PC push/pop (stalls)
    // SECOND | second half of a PC push/pop; held instruction retires
    typedef enum logic {IDLE, SECOND} state_t;

    localparam int DEPTH = 2**ADDR_W;

    logic [15:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] sp_q, sp_d;
    logic              pop_op_q, pop_op_d;
    logic [15:0]       low_q, low_d;
    logic [15:0]       load_q, load_d;
    logic [15:0]       rd_q, rd_d;
    logic              wb_q, wb_d;
    logic              pw_q, pw_d;
    logic [2:0]        rda_q, rda_d;
    logic              rw_q, rw_d;
    logic [31:0]       pc_q, pc_d;
    logic              pcv_q, pcv_d;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [15:0]       mem_wdata;

    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] sp_p1, sp_p2, sp_m1, sp_m2;

    assign addr  = alu_result[ADDR_W-1:0];
    assign sp_p1 = sp_q + ADDR_W'(1);
    assign sp_p2 = sp_q + ADDR_W'(2);
    assign sp_m1 = sp_q - ADDR_W'(1);
    assign sp_m2 = sp_q - ADDR_W'(2);

    always_comb begin
        state_d   = state_q;
        sp_d      = sp_q;
        pop_op_d  = pop_op_q;
        low_d     = low_q;
        pc_d      = pc_q;
        pcv_d     = 1'b0;
        load_d    = 16'h0000;
        rd_d      = alu_result;
        wb_d      = wb_in;
        pw_d      = port_write_in;
        rda_d     = rd_addr_in;
        rw_d      = reg_write_in;
        mem_we    = 1'b0;
        mem_waddr = sp_q;
        mem_wdata = rd_data;
        stall     = 1'b0;

        if (state_q == IDLE) begin
            if (pop_pc || push_pc) begin
                // first half of a PC transfer: upstream holds, MEM/WB gets a bubble
                stall   = 1'b1;
                state_d = SECOND;
                rd_d    = 16'h0000;
                wb_d    = 1'b0;
                pw_d    = 1'b0;
                rda_d   = 3'd0;
                rw_d    = 1'b0;
                if (pop_pc) begin
                    pop_op_d = 1'b1;
                    low_d    = mem[sp_p1];
                end else begin
                    pop_op_d  = 1'b0;
                    mem_we    = 1'b1;
                    mem_wdata = pc_in[31:16];
                end
            end else if (pop) begin
                load_d = mem[sp_p1];
                sp_d   = sp_p1;
            end else if (push) begin
                mem_we = 1'b1;
                sp_d   = sp_m1;
            end else if (mem_write) begin
                mem_we    = 1'b1;
                mem_waddr = addr;
            end else if (mem_read) begin
                load_d = mem[addr];
            end
        end else begin
            state_d = IDLE;
            if (pop_op_q) begin
                pc_d  = {mem[sp_p2], low_q};
                pcv_d = 1'b1;
                sp_d  = sp_p2;
            end else begin
                mem_we    = 1'b1;
                mem_waddr = sp_m1;
                mem_wdata = pc_in[15:0];
                sp_d      = sp_m2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            sp_q     <= SP_RESET;
            pop_op_q <= 1'b0;
            low_q    <= 16'h0000;
            load_q   <= 16'h0000;
            rd_q     <= 16'h0000;
            wb_q     <= 1'b0;
            pw_q     <= 1'b0;
            rda_q    <= 3'd0;
            rw_q     <= 1'b0;
            pc_q     <= 32'h0000_0000;
            pcv_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sp_q     <= sp_d;
            pop_op_q <= pop_op_d;
            low_q    <= low_d;
            load_q   <= load_d;
            rd_q     <= rd_d;
            wb_q     <= wb_d;
            pw_q     <= pw_d;
            rda_q    <= rda_d;
            rw_q     <= rw_d;
            pc_q     <= pc_d;
            pcv_q    <= pcv_d;
        end
    end

    // Memory contents survive reset; writes are suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (rst && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign load_out       = load_q;
    assign rd_out         = rd_q;
    assign wb_out         = wb_q;
    assign port_write_out = pw_q;
    assign rd_addr_out    = rda_q;
    assign reg_write_out  = rw_q;
    assign pc_out         = pc_q;
    assign pc_valid       = pcv_q;
    assign sp_out         = sp_q;

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: transaction-level reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_memory_stage;

    localparam int AW    = 11;
    localparam int DEPTH = 2048;

    localparam logic [5:0] C_NONE = 6'b000000;
    localparam logic [5:0] C_RD   = 6'b000001;
    localparam logic [5:0] C_WR   = 6'b000010;
    localparam logic [5:0] C_PUSH = 6'b000100;
    localparam logic [5:0] C_POP  = 6'b001000;
    localparam logic [5:0] C_PPC  = 6'b010000;
    localparam logic [5:0] C_OPC  = 6'b100000;

    logic          clk;
    logic          rst;
    logic          mem_read, mem_write, push, pop, push_pc, pop_pc;
    logic [15:0]   alu_result, rd_data;
    logic [31:0]   pc_in;
    logic          wb_in, port_write_in, reg_write_in;
    logic [2:0]    rd_addr_in;
    logic [15:0]   load_out, rd_out;
    logic          wb_out, port_write_out, reg_write_out;
    logic [2:0]    rd_addr_out;
    logic [31:0]   pc_out;
    logic          pc_valid, stall;
    logic [AW-1:0] sp_out;

    memory_stage dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write),
        .push(push), .pop(pop), .push_pc(push_pc), .pop_pc(pop_pc),
        .alu_result(alu_result), .rd_data(rd_data), .pc_in(pc_in),
        .wb_in(wb_in), .port_write_in(port_write_in),
        .rd_addr_in(rd_addr_in), .reg_write_in(reg_write_in),
        .load_out(load_out), .rd_out(rd_out), .wb_out(wb_out),
        .port_write_out(port_write_out), .rd_addr_out(rd_addr_out),
        .reg_write_out(reg_write_out), .pc_out(pc_out), .pc_valid(pc_valid),
        .stall(stall), .sp_out(sp_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: word array plus stack pointer; a PC transfer is one
    // 32-bit operation that occupies two cycles (pending = 1 push, 2 pop).
    logic [15:0] mm [DEPTH];
    int          msp;
    int          pending;
    bit          model_ok = 0;
    logic [15:0] e_load, e_rd;
    logic        e_wb, e_pw, e_rw, e_pcv;
    logic [2:0]  e_rda;
    logic [31:0] e_pc;

    function automatic int wrap(input int v);
        return (v % DEPTH + DEPTH) % DEPTH;
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            msp = DEPTH - 1; pending = 0; model_ok = 1;
            e_load = 0; e_rd = 0; e_wb = 0; e_pw = 0; e_rda = 0; e_rw = 0;
            e_pc = 0; e_pcv = 0;
        end else if (pending == 0 && (pop_pc || push_pc)) begin
            e_load = 0; e_rd = 0; e_wb = 0; e_pw = 0; e_rda = 0; e_rw = 0; e_pcv = 0;
            if (pop_pc) pending = 2;
            else begin
                mm[msp] = pc_in[31:16];
                pending = 1;
            end
        end else begin
            e_rd = alu_result; e_wb = wb_in; e_pw = port_write_in;
            e_rda = rd_addr_in; e_rw = reg_write_in; e_load = 0; e_pcv = 0;
            if (pending == 2) begin
                e_pc  = {mm[wrap(msp + 2)], mm[wrap(msp + 1)]};
                e_pcv = 1;
                msp   = wrap(msp + 2);
            end else if (pending == 1) begin
                mm[wrap(msp - 1)] = pc_in[15:0];
                msp = wrap(msp - 2);
            end else if (pop) begin
                msp    = wrap(msp + 1);
                e_load = mm[msp];
            end else if (push) begin
                mm[msp] = rd_data;
                msp     = wrap(msp - 1);
            end else if (mem_write) begin
                mm[alu_result[AW-1:0]] = rd_data;
            end else if (mem_read) begin
                e_load = mm[alu_result[AW-1:0]];
            end
            pending = 0;
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("load_out", 32'(load_out), 32'(e_load));
            chk("rd_out", 32'(rd_out), 32'(e_rd));
            chk("wb_out", 32'(wb_out), 32'(e_wb));
            chk("port_write_out", 32'(port_write_out), 32'(e_pw));
            chk("rd_addr_out", 32'(rd_addr_out), 32'(e_rda));
            chk("reg_write_out", 32'(reg_write_out), 32'(e_rw));
            chk("pc_valid", 32'(pc_valid), 32'(e_pcv));
            chk("pc_out", pc_out, e_pc);
            chk("sp_out", 32'(sp_out), 32'(msp));
            chk("stall", 32'(stall), 32'(pending == 0 && (push_pc || pop_pc)));
        end
    end

    task automatic set_in(input logic [5:0] cmd, input logic [15:0] alu, input logic [15:0] rdd,
                          input logic [31:0] pc, input logic wb, input logic pw,
                          input logic [2:0] rda, input logic rw);
        {pop_pc, push_pc, pop, push, mem_write, mem_read} = cmd;
        alu_result = alu; rd_data = rdd; pc_in = pc;
        wb_in = wb; port_write_in = pw; rd_addr_in = rda; reg_write_in = rw;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] cmd, input logic [15:0] alu, input logic [15:0] rdd,
                         input logic [31:0] pc, input logic wb);
        set_in(cmd, alu, rdd, pc, wb, 1'b0, 3'd1, 1'b1);
        step();
        if (cmd[5] || cmd[4]) step();
    endtask

    logic [15:0] saved;
    logic [5:0]  rcmd;

    initial begin
        rst = 1'b0;
        set_in(C_NONE, 0, 0, 0, 0, 0, 0, 0);
        step(); step();
        chk("reset_load", 32'(load_out), 0);
        chk("reset_sp", 32'(sp_out), 32'h7FF);
        chk("reset_pcv", 32'(pc_valid), 0);
        rst = 1'b1;

        for (int i = 0; i < DEPTH; i++)
            issue(C_WR, 16'(i), 16'($urandom), 0, 0);

        issue(C_WR, 16'h0010, 16'hBEEF, 0, 0);
        issue(C_RD, 16'h0010, 0, 0, 1);
        chk("load_beef", 32'(load_out), 32'hBEEF);
        chk("load_wb", 32'(wb_out), 1);

        issue(C_PUSH, 0, 16'h1234, 0, 0);
        chk("push1_sp", 32'(sp_out), 32'h7FE);
        issue(C_PUSH, 0, 16'h5678, 0, 0);
        chk("push2_sp", 32'(sp_out), 32'h7FD);
        issue(C_POP, 0, 0, 0, 1);
        chk("pop1_data", 32'(load_out), 32'h5678);
        chk("pop1_sp", 32'(sp_out), 32'h7FE);
        issue(C_POP, 0, 0, 0, 1);
        chk("pop2_data", 32'(load_out), 32'h1234);
        chk("pop2_sp", 32'(sp_out), 32'h7FF);

        set_in(C_PPC, 0, 0, 32'hAABBCCDD, 0, 1, 3'd2, 1);
        #1 chk("pushpc_stall1", 32'(stall), 1);
        step();
        chk("pushpc_stall2", 32'(stall), 0);
        step();
        chk("pushpc_sp", 32'(sp_out), 32'h7FD);
        issue(C_RD, 16'h07FF, 0, 0, 1);
        chk("pushpc_hi", 32'(load_out), 32'hAABB);
        issue(C_RD, 16'h07FE, 0, 0, 1);
        chk("pushpc_lo", 32'(load_out), 32'hCCDD);

        saved = mm[16'h0020];
        set_in(C_OPC | C_WR, 16'h0020, 16'h9999, 0, 1, 1, 3'd5, 1);
        step();
        chk("bubble_rw", 32'(reg_write_out), 0);
        chk("bubble_pw", 32'(port_write_out), 0);
        step();
        chk("poppc_valid", 32'(pc_valid), 1);
        chk("poppc_pc", pc_out, 32'hAABBCCDD);
        chk("poppc_sp", 32'(sp_out), 32'h7FF);
        chk("poppc_rw", 32'(reg_write_out), 1);
        issue(C_NONE, 0, 0, 0, 0);
        chk("poppc_pulse", 32'(pc_valid), 0);
        issue(C_RD, 16'h0020, 0, 0, 1);
        chk("poppc_nowrite", 32'(load_out), 32'(saved));

        saved = mm[0];
        issue(C_POP, 0, 0, 0, 1);
        chk("wrap_pop_sp", 32'(sp_out), 0);
        chk("wrap_pop_data", 32'(load_out), 32'(saved));
        issue(C_PUSH, 0, 16'h4242, 0, 0);
        chk("wrap_push_sp", 32'(sp_out), 32'h7FF);
        issue(C_RD, 16'h0000, 0, 0, 1);
        chk("wrap_push_data", 32'(load_out), 32'h4242);

        issue(C_PUSH, 0, 16'h0F0F, 0, 0);
        saved = mm[16'h07FD];
        set_in(C_PPC, 16'h0033, 0, 32'h13572468, 1, 1, 3'd7, 1);
        step();
        rst = 1'b0;
        set_in(C_NONE, 16'h0033, 0, 0, 1, 1, 3'd7, 1);
        step();
        chk("rst2_sp", 32'(sp_out), 32'h7FF);
        chk("rst2_stall", 32'(stall), 0);
        chk("rst2_pcv", 32'(pc_valid), 0);
        chk("rst2_rd", 32'(rd_out), 0);
        chk("rst2_rw", 32'(reg_write_out), 0);
        rst = 1'b1;
        issue(C_RD, 16'h07FE, 0, 0, 1);
        chk("rst2_hi_kept", 32'(load_out), 32'h1357);
        issue(C_RD, 16'h07FD, 0, 0, 1);
        chk("rst2_lo_skipped", 32'(load_out), 32'(saved));

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b0;
                set_in(C_NONE, 0, 0, 0, 0, 0, 0, 0);
                step();
                rst = 1'b1;
            end
            for (int b = 0; b < 6; b++) rcmd[b] = ($urandom_range(0, 4) == 0);
            set_in(rcmd, 16'($urandom), 16'($urandom), $urandom, 1'($urandom),
                   1'($urandom), 3'($urandom), 1'($urandom));
            step();
            if (rcmd[5] || rcmd[4]) step();
        end

        set_in(C_NONE, 0, 0, 0, 0, 0, 0, 0);
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
